// File: rtl/usr_pkg.sv
// ============================================================================
// Module : usr_pkg
// Brief  : Shared op/state types and helpers for the universal shift register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package usr_pkg;

   typedef enum logic [2:0] {
      HOLD = 3'd0,
      LOAD = 3'd1,
      SHUP = 3'd2,
      SHDN = 3'd3,
      ROUP = 3'd4,
      RODN = 3'd5,
      ASDN = 3'd6,
      CLR  = 3'd7
   } tOpUsr;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tStateUsr;

   // Only these ops are worth repeating; the rest are idempotent single steps.
   function automatic logic isShiftOp(input tOpUsr op);
      return (op == SHUP) || (op == SHDN) || (op == ROUP) ||
             (op == RODN) || (op == ASDN);
   endfunction

endpackage

`default_nettype wire

// File: rtl/usr_step.sv
// ============================================================================
// Module : usr_step
// Brief  : Combinational single-step next value of the shift register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module usr_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 36
) (
   input  tOpUsr              op_i,
   input  logic [0:WIDTH-1]   q_i,
   input  logic [0:WIDTH-1]   d_i,
   input  logic               sin0_i,
   input  logic               sinN_i,
   output logic [0:WIDTH-1]   q_o
);

   // Bit 0 is the MSB, so "up" moves data toward index 0.
   always_comb begin
      q_o = q_i;
      case (op_i)
         HOLD: q_o = q_i;
         LOAD: q_o = d_i;
         SHUP: q_o = {q_i[1:WIDTH-1], sinN_i};
         SHDN: q_o = {sin0_i, q_i[0:WIDTH-2]};
         ROUP: q_o = {q_i[1:WIDTH-1], q_i[0]};
         RODN: q_o = {q_i[WIDTH-1], q_i[0:WIDTH-2]};
         ASDN: q_o = {q_i[0], q_i[0:WIDTH-2]};
         CLR:  q_o = '0;
         default: q_o = q_i;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/univ_shift_seq.sv
// ============================================================================
// Module : univ_shift_seq
// Brief  : Universal shift/rotate register with counted multi-cycle sequencer.
//          Define USR_BARREL_EN to finish counted sequences in one edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module univ_shift_seq
   import usr_pkg::*;
#(
   parameter int WIDTH = 36,
   parameter int CW    = $clog2(WIDTH+1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  tOpUsr              op,
   input  logic               start,
   input  logic [CW-1:0]      count,
   input  logic [0:WIDTH-1]   d,
   input  logic               sin0,
   input  logic               sinN,
   output logic [0:WIDTH-1]   q,
   output logic               sout0,
   output logic               soutN,
   output logic               busy,
   output logic               done
);

   localparam logic [CW-1:0] ONE_C = CW'(1);

   logic [0:WIDTH-1] q_q, q_d, step_q;
   tStateUsr         state_q, state_d;
   tOpUsr            op_q, op_d;
   tOpUsr            step_op;
   logic [CW-1:0]    rem_q, rem_d;
   logic             done_q, done_d;

   // The same step logic serves direct mode and every RUN iteration.
   assign step_op = (state_q == RUN) ? op_q : op;

   usr_step #(.WIDTH(WIDTH)) u_step (
      .op_i   (step_op),
      .q_i    (q_q),
      .d_i    (d),
      .sin0_i (sin0),
      .sinN_i (sinN),
      .q_o    (step_q)
   );

`ifdef USR_BARREL_EN
   localparam logic [CW-1:0] W_C = CW'(WIDTH);
   logic [CW-1:0]    sh_amt, ro_amt;
   logic [0:WIDTH-1] ones, barrel_q;

   // Shifts saturate at WIDTH; rotates wrap modulo WIDTH.
   always_comb begin
      sh_amt = (count > W_C) ? W_C : count;
      ro_amt = count % W_C;
      ones   = '1;
      case (op)
         SHUP:    barrel_q = (q_q << sh_amt) | (~(ones << sh_amt) & {WIDTH{sinN}});
         SHDN:    barrel_q = (q_q >> sh_amt) | (~(ones >> sh_amt) & {WIDTH{sin0}});
         ASDN:    barrel_q = (q_q >> sh_amt) | (~(ones >> sh_amt) & {WIDTH{q_q[0]}});
         ROUP:    barrel_q = (q_q << ro_amt) | (q_q >> (W_C - ro_amt));
         RODN:    barrel_q = (q_q >> ro_amt) | (q_q << (W_C - ro_amt));
         default: barrel_q = q_q;
      endcase
   end
`endif

   always_comb begin
      q_d     = q_q;
      state_d = state_q;
      op_d    = op_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!start) begin
               q_d = step_q;
            end else if (count == '0) begin
               done_d = 1'b1;
            end else if (!isShiftOp(op)) begin
               q_d    = step_q;
               done_d = 1'b1;
            end else begin
`ifdef USR_BARREL_EN
               q_d    = barrel_q;
               done_d = 1'b1;
`else
               q_d   = step_q;
               op_d  = op;
               rem_d = count - ONE_C;
               if (count == ONE_C) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
`endif
            end
         end
         RUN: begin
            q_d   = step_q;
            rem_d = rem_q - ONE_C;
            if (rem_q == ONE_C) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q     <= '0;
         state_q <= IDLE;
         op_q    <= HOLD;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         q_q     <= q_d;
         state_q <= state_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   assign q     = q_q;
   assign sout0 = q_q[0];
   assign soutN = q_q[WIDTH-1];
   assign busy  = (state_q == RUN);
   assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_seq.sv
// ============================================================================
// Module : tb_univ_shift_seq
// Brief  : Directed scoreboard bench for univ_shift_seq (WIDTH=36).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_seq;
   import usr_pkg::*;

   localparam int W  = 36;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   tOpUsr         op;
   logic          start;
   logic [CW-1:0] count;
   logic [0:W-1]  d;
   logic          sin0, sinN;
   logic [0:W-1]  q;
   logic          sout0, soutN, busy, done;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string        tag;
      logic [0:W-1] q;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t sb[$];
   logic [0:W-1] m;

   univ_shift_seq #(.WIDTH(W), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .start(start), .count(count),
      .d(d), .sin0(sin0), .sinN(sinN), .q(q), .sout0(sout0), .soutN(soutN),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Bit-level reference for a single step, bit 0 = MSB.
   function automatic logic [0:W-1] ref_step(input tOpUsr o, input logic [0:W-1] v,
                                             input logic [0:W-1] dd, input logic s0, sN);
      logic [0:W-1] r;
      r = v;
      case (o)
         LOAD: r = dd;
         SHUP: begin for (int i = 0; i < W-1; i++) r[i] = v[i+1]; r[W-1] = sN; end
         SHDN: begin for (int i = 1; i < W; i++) r[i] = v[i-1]; r[0] = s0; end
         ROUP: begin for (int i = 0; i < W-1; i++) r[i] = v[i+1]; r[W-1] = v[0]; end
         RODN: begin for (int i = 1; i < W; i++) r[i] = v[i-1]; r[0] = v[W-1]; end
         ASDN: begin for (int i = 1; i < W; i++) r[i] = v[i-1]; r[0] = v[0]; end
         CLR:  r = '0;
         default: r = v;
      endcase
      return r;
   endfunction

   task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [0:W-1] eq, input logic eb, input logic ed);
      exp_t e;
      e.tag = tag; e.q = eq; e.busy = eb; e.done = ed;
      sb.push_back(e);
   endtask

   task automatic tick_pop();
      exp_t e;
      @(posedge clk); #1;
      if (sb.size() == 0) begin
         cmp("scoreboard_empty", 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         cmp({e.tag, ".q"}, 64'(q), 64'(e.q));
         cmp({e.tag, ".busy"}, 64'(busy), 64'(e.busy));
         cmp({e.tag, ".done"}, 64'(done), 64'(e.done));
         cmp({e.tag, ".sout0"}, 64'(sout0), 64'(e.q[0]));
         cmp({e.tag, ".soutN"}, 64'(soutN), 64'(e.q[W-1]));
      end
   endtask

   task automatic drive(input tOpUsr o, input logic st, input logic [CW-1:0] c, input logic [0:W-1] dd);
      op = o; start = st; count = c; d = dd;
   endtask

   initial begin
      tOpUsr dops[7];
      int    edges;
      dops = '{SHUP, SHDN, ROUP, RODN, ASDN, HOLD, SHDN};

      rst_n = 1'b0; sin0 = 1'b0; sinN = 1'b0;
      drive(HOLD, 1'b0, '0, '0);
      #12;
      cmp("reset.q", 64'(q), 64'd0);
      cmp("reset.busy", 64'(busy), 64'd0);
      cmp("reset.done", 64'(done), 64'd0);
      rst_n = 1'b1;

      // Reset aborting a RUN sequence
      drive(LOAD, 1'b0, '0, 36'o777000000000);
      push("t1.load", 36'o777000000000, 1'b0, 1'b0); tick_pop();
      drive(SHUP, 1'b1, 6'd10, '0);
      push("t1.s1", 36'o776000000000, 1'b1, 1'b0); tick_pop();
      drive(HOLD, 1'b0, '0, '0);
      push("t1.s2", 36'o774000000000, 1'b1, 1'b0); tick_pop();
      push("t1.s3", 36'o770000000000, 1'b1, 1'b0); tick_pop();
      push("t1.s4", 36'o760000000000, 1'b1, 1'b0); tick_pop();
      #2 rst_n = 1'b0;
      #1;
      cmp("t1.async.q", 64'(q), 64'd0);
      cmp("t1.async.busy", 64'(busy), 64'd0);
      cmp("t1.async.done", 64'(done), 64'd0);
      #10 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push("t1.after", '0, 1'b0, 1'b0); tick_pop();
      end

      // ROUP count=1
      drive(LOAD, 1'b0, '0, 36'o400000000001);
      push("t2.load", 36'o400000000001, 1'b0, 1'b0); tick_pop();
      drive(ROUP, 1'b1, 6'd1, '0);
      push("t2.rot", 36'o000000000003, 1'b0, 1'b1); tick_pop();
      drive(HOLD, 1'b0, '0, '0);
      push("t2.idle", 36'o000000000003, 1'b0, 1'b0); tick_pop();

      // ASDN count=3
      drive(LOAD, 1'b0, '0, 36'o400000000000);
      push("t3.load", 36'o400000000000, 1'b0, 1'b0); tick_pop();
      drive(ASDN, 1'b1, 6'd3, '0);
      push("t3.s1", 36'o600000000000, 1'b1, 1'b0); tick_pop();
      drive(HOLD, 1'b0, '0, '0);
      push("t3.s2", 36'o700000000000, 1'b1, 1'b0); tick_pop();
      push("t3.s3", 36'o740000000000, 1'b0, 1'b1); tick_pop();
      push("t3.idle", 36'o740000000000, 1'b0, 1'b0); tick_pop();

      // SHUP count=4 with sinN=1; live LOAD ignored
      drive(CLR, 1'b0, '0, '0);
      push("t4.clr", '0, 1'b0, 1'b0); tick_pop();
      sinN = 1'b1;
      drive(SHUP, 1'b1, 6'd4, '0);
      push("t4.s1", 36'o1, 1'b1, 1'b0); tick_pop();
      drive(LOAD, 1'b0, '0, '1);
      push("t4.s2", 36'o3, 1'b1, 1'b0); tick_pop();
      push("t4.s3", 36'o7, 1'b1, 1'b0); tick_pop();
      push("t4.s4", 36'o17, 1'b0, 1'b1); tick_pop();
      drive(HOLD, 1'b0, '0, '0); sinN = 1'b0;
      push("t4.idle", 36'o17, 1'b0, 1'b0); tick_pop();

      // RODN count=36 returns original; restart during busy ignored
      drive(LOAD, 1'b0, '0, 36'o123456701234);
      m = 36'o123456701234;
      push("t5.load", m, 1'b0, 1'b0); tick_pop();
      for (int i = 1; i <= W; i++) begin
         if (i == 1)      drive(RODN, 1'b1, 6'd36, '0);
         else if (i == 2) drive(CLR, 1'b1, 6'd1, '0);
         else             drive(HOLD, 1'b0, '0, '0);
         m = ref_step(RODN, m, '0, 1'b0, 1'b0);
         push("t5.step", m, (i != W), (i == W)); tick_pop();
      end
      cmp("t5.final", 64'(q), 64'(36'o123456701234));
      push("t5.idle", 36'o123456701234, 1'b0, 1'b0); tick_pop();

      // count=0 leaves q alone; start with LOAD is a single step
      sin0 = 1'b1;
      drive(SHDN, 1'b1, 6'd0, '0);
      push("t6.cnt0", 36'o123456701234, 1'b0, 1'b1); tick_pop();
      drive(LOAD, 1'b1, 6'd5, 36'o555000000777);
      push("t6.load", 36'o555000000777, 1'b0, 1'b1); tick_pop();
      drive(HOLD, 1'b0, '0, '0); sin0 = 1'b0;
      push("t6.idle", 36'o555000000777, 1'b0, 1'b0); tick_pop();

      // Direct mode with random serial fills
      m = 36'o555000000777;
      for (int i = 0; i < 7; i++) begin
         sin0 = 1'($urandom); sinN = 1'($urandom);
         drive(dops[i], 1'b0, '0, '0);
         m = ref_step(dops[i], m, '0, sin0, sinN);
         push("direct", m, 1'b0, 1'b0); tick_pop();
      end
      sin0 = 1'b0; sinN = 1'b0;

      // count>WIDTH: ROUP 37 equals ROUP 1
      drive(LOAD, 1'b0, '0, 36'o400000000001);
      push("t7.load", 36'o400000000001, 1'b0, 1'b0); tick_pop();
      drive(ROUP, 1'b1, 6'd37, '0);
      @(posedge clk); #1;
      edges = 1;
      drive(HOLD, 1'b0, '0, '0);
      while (!done && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
      cmp("t7.done", 64'(done), 64'd1);
      cmp("t7.q", 64'(q), 64'(36'o000000000003));
`ifdef USR_BARREL_EN
      cmp("t7.edges", 64'(edges), 64'd1);
`else
      cmp("t7.edges", 64'(edges), 64'd37);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
